// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux datapath.
// Grants are registered; the selected data is registered one cycle later onto M.
module mux2_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             S,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] M,
    output logic             valid
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                last_q, last_d;
    logic                s_q, s_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic                valid_q, valid_d;

    logic                own_req;
    logic                oth_req;
    state_t              oth_state;

    always_comb begin
        own_req   = 1'b0;
        oth_req   = 1'b0;
        oth_state = IDLE;
        unique case (state_q)
            GNT0: begin
                own_req   = req0;
                oth_req   = req1;
                oth_state = GNT1;
            end
            GNT1: begin
                own_req   = req1;
                oth_req   = req0;
                oth_state = GNT0;
            end
            default: begin
                own_req   = 1'b0;
                oth_req   = 1'b0;
                oth_state = IDLE;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (req0 && req1) begin
                    // Tie goes to the side that was not served last.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    state_d = oth_req ? oth_state : IDLE;
                    hold_d  = '0;
                    last_d  = (state_q == GNT1);
                end else if (oth_req && hold_q == HOLD_MAX) begin
                    state_d = oth_state;
                    hold_d  = '0;
                    last_d  = (state_q == GNT1);
                end else if (hold_q != HOLD_MAX) begin
                    hold_d  = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        gnt0_d  = (state_d == GNT0);
        gnt1_d  = (state_d == GNT1);
        s_d     = (state_d == GNT1);
        valid_d = gnt0_q | gnt1_q;
        m_d     = m_q;
        if (gnt0_q | gnt1_q) begin
            m_d = s_q ? Y : X;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            m_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            s_q     <= s_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            m_q     <= m_d;
            valid_q <= valid_d;
        end
    end

    assign S     = s_q;
    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign M     = m_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share random stimulus and are checked against a grant-run model.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] x, y;

    logic       s    [2];
    logic       g0   [2];
    logic       g1   [2];
    logic       v    [2];
    logic [7:0] m    [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: owner -1 idle, 0/1 granted side; run = cycles in grant.
    int         own  [2];
    int         run  [2];
    int         lst  [2];
    logic [7:0] em   [2];
    bit         ev   [2];
    int         mh   [2] = '{4, 1};

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .X(x), .Y(y), .S(s[0]), .gnt0(g0[0]), .gnt1(g1[0]),
        .M(m[0]), .valid(v[0])
    );

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .X(x), .Y(y), .S(s[1]), .gnt0(g0[1]), .gnt1(g1[1]),
        .M(m[1]), .valid(v[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                own[i] = -1; run[i] = 0; lst[i] = 1;
                em[i] = 8'h00; ev[i] = 1'b0;
            end else begin
                int nxt;
                bit r_own, r_oth;
                ev[i] = (own[i] >= 0);
                if (own[i] >= 0) em[i] = (own[i] == 1) ? y : x;
                r_own = (own[i] == 0) ? req0 : req1;
                r_oth = (own[i] == 0) ? req1 : req0;
                nxt = own[i];
                if (own[i] < 0) begin
                    if (req0 && req1) nxt = 1 - lst[i];
                    else if (req0)    nxt = 0;
                    else if (req1)    nxt = 1;
                end else if (!r_own || (r_oth && run[i] >= mh[i])) begin
                    nxt = r_oth ? 1 - own[i] : -1;
                    lst[i] = own[i];
                end
                if (nxt == own[i]) begin
                    if (nxt >= 0) run[i]++;
                end else begin
                    run[i] = (nxt >= 0) ? 1 : 0;
                end
                own[i] = nxt;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("gnt0[%0d]", i), 32'(g0[i]), 32'(own[i] == 0));
            check($sformatf("gnt1[%0d]", i), 32'(g1[i]), 32'(own[i] == 1));
            check($sformatf("S[%0d]", i), 32'(s[i]), 32'(own[i] == 1));
            check($sformatf("valid[%0d]", i), 32'(v[i]), 32'(ev[i]));
            check($sformatf("M[%0d]", i), 32'(m[i]), 32'(em[i]));
            check($sformatf("excl[%0d]", i), 32'(g0[i] & g1[i]), 32'd0);
        end
    endtask

    task automatic cyc(input logic r, input logic a, input logic b,
                       input logic [7:0] xv, input logic [7:0] yv);
        @(negedge clk);
        reset = r; req0 = a; req1 = b; x = xv; y = yv;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; x = 8'h11; y = 8'h22;
        cyc(1, 1, 1, 8'h11, 8'h22);
        cyc(1, 1, 1, 8'h11, 8'h22);
        check("rst_gnt0", 32'(g0[0]), 32'd0);
        check("rst_M", 32'(m[0]), 32'd0);

        // Continuous contention: 4/4 on instance A, strict alternation on B.
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 1, 8'h11, 8'h22);
            check($sformatf("cont_a_%0d", k), 32'(g0[0]), 32'(((k - 1) % 8) < 4));
            check($sformatf("cont_b_%0d", k), 32'(g0[1]), 32'(k % 2));
        end

        // Single requester, release, tie after idle, early release.
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 8'hA5, 8'h00);
        check("single_M", 32'(m[0]), 32'hA5);
        cyc(0, 0, 0, 8'hA5, 8'h00);
        cyc(0, 0, 0, 8'hA5, 8'h00);
        cyc(0, 1, 1, 8'h33, 8'h44);
        check("tie_idle", 32'(g1[0]), 32'd1);
        cyc(0, 1, 1, 8'h33, 8'h44);
        cyc(0, 1, 0, 8'h33, 8'h44);
        check("early_rel", 32'(g0[0]), 32'd1);

        // Reset in the middle of a grant.
        cyc(0, 0, 1, 8'h55, 8'h66);
        cyc(0, 0, 1, 8'h55, 8'h66);
        cyc(1, 0, 1, 8'h55, 8'h66);
        check("mid_rst_valid", 32'(v[0]), 32'd0);
        cyc(0, 0, 1, 8'h55, 8'h66);
        check("post_rst_gnt1", 32'(g1[0]), 32'd1);

        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
